// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared encodings for the load/store unit.
//   SZ_*          access size encodings on the size port
//   lsu_state_e   FSM state encoding
//   is_bad_access misaligned / reserved-size detection
package mem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } lsu_state_e;

  // Halfwords need addr[0]=0, words need addr[1:0]=0; reserved size always faults.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      SZ_HALF: bad = a[0];
      SZ_WORD: bad = |a;
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request/response bundle between the control path and the LSU,
// plus the LSU's word-memory port.
//   slave  : LSU side (takes requests, drives memory address/data/enable)
//   master : requester + memory side (drives requests and mem_rd)
interface mem_lsu_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  modport slave (
    input  req, wr, size, sign_ext, addr, wdata, mem_rd,
    output busy, done, err, rdata, mem_address, mem_wd, mem_we
  );

  modport master (
    output req, wr, size, sign_ext, addr, wdata, mem_rd,
    input  busy, done, err, rdata, mem_address, mem_wd, mem_we
  );
endinterface

// File: rtl/mem_lane_mux.sv
// mem_lane_mux: combinational byte/half lane select for the LSU.
//   word     memory word being accessed
//   a        addr[1:0] of the access
//   size     SZ_* encoding
//   sign_ext extend loads with sign (1) or zeros (0)
//   wdata_lo low 16 bits of store data
//   ld_val   extracted and extended load value
//   st_word  word with the addressed lane replaced by store data
module mem_lane_mux
  import mem_lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] word,
  input  logic [1:0]  a,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [15:0] wdata_lo,
  output logic [31:0] ld_val,
  output logic [31:0] st_word
);

  logic [1:0]  byte_lane;
  logic        half_lane;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    // Big-endian puts byte offset 0 in the top lane: lane = 3-k = ~k.
    byte_lane = BIG_ENDIAN ? ~a : a;
    half_lane = BIG_ENDIAN ? ~a[1] : a[1];
    b = word[8*byte_lane +: 8];
    h = word[16*half_lane +: 16];

    case (size)
      SZ_BYTE: ld_val = {{24{sign_ext & b[7]}}, b};
      SZ_HALF: ld_val = {{16{sign_ext & h[15]}}, h};
      default: ld_val = word;
    endcase

    st_word = word;
    case (size)
      SZ_BYTE: st_word[8*byte_lane +: 8]   = wdata_lo[7:0];
      SZ_HALF: st_word[16*half_lane +: 16] = wdata_lo;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store initiator turning byte/half/word accesses into word
// accesses on a single-ported word memory. Sub-word stores read-modify-write.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mem_lsu_if.slave (request, status, load result, memory port)
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_lsu_if.slave bus
);

  lsu_state_e  state_q, state_d;
  logic        wr_q, wr_d;
  logic        sext_q, sext_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  alo_q, alo_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] maddr_q, maddr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [31:0] lane_word, ld_val, st_word;

  // Loads extract straight from the memory read in ACCESS; merges in WRITE
  // work on the word buffered at the end of ACCESS.
  assign lane_word = (state_q == S_ACCESS) ? bus.mem_rd : buf_q;

  mem_lane_mux #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .word     (lane_word),
    .a        (alo_q),
    .size     (size_q),
    .sign_ext (sext_q),
    .wdata_lo (wdata_q[15:0]),
    .ld_val   (ld_val),
    .st_word  (st_word)
  );

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    sext_d  = sext_q;
    size_d  = size_q;
    alo_d   = alo_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    maddr_d = maddr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          wr_d    = bus.wr;
          size_d  = bus.size;
          sext_d  = bus.sign_ext;
          alo_d   = bus.addr[1:0];
          wdata_d = bus.wdata;
          if (is_bad_access(bus.size, bus.addr[1:0])) begin
            // Faulting accesses leave the memory address untouched.
            state_d = S_ERR;
          end else begin
            maddr_d = {bus.addr[31:2], 2'b00};
            state_d = (bus.wr && bus.size == SZ_WORD) ? S_WRITE : S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        buf_d = bus.mem_rd;
        if (wr_q) begin
          state_d = S_WRITE;
        end else begin
          rdata_d = ld_val;
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE) || (state_d == S_ERR);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= 2'b00;
      alo_q   <= 2'b00;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      maddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      sext_q  <= sext_d;
      size_q  <= size_d;
      alo_q   <= alo_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      maddr_q <= maddr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.rdata       = rdata_q;
  assign bus.mem_address = maddr_q;
  // Gated by rst_n so a reset landing on WRITE never commits a write.
  assign bus.mem_we      = (state_q == S_WRITE) & rst_n;
  assign bus.mem_wd      = (state_q != S_WRITE) ? '0 :
                           (size_q == SZ_WORD)  ? wdata_q : st_word;

endmodule
